// File: rtl/ram_io_pkg.sv
// Shared constants, types and helpers for the RAM_IO read-data path.
package ram_io_pkg;

    localparam int NIBBLE_W      = 4;
    localparam int CFG_ORDER_BIT = 0;
    localparam int CFG_IDLE_BIT  = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    function automatic int beats(input int data_width);
        return data_width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_shift_reg.sv
// Word shifter that presents one nibble at its output end; direction is latched at load.
module nibble_shift_reg
    import ram_io_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic                  msb_first_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [NIBBLE_W-1:0]   nibble_o
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  msb_first_q, msb_first_d;

    always_comb begin
        data_d      = data_q;
        msb_first_d = msb_first_q;
        if (load_i) begin
            data_d      = data_i;
            msb_first_d = msb_first_i;
        end else if (shift_i) begin
            // The output end is the top nibble for MSB-first, the bottom nibble otherwise.
            if (msb_first_q) begin
                data_d = {data_q[DATA_WIDTH-NIBBLE_W-1:0], {NIBBLE_W{1'b0}}};
            end else begin
                data_d = {{NIBBLE_W{1'b0}}, data_q[DATA_WIDTH-1:NIBBLE_W]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            data_q      <= '0;
            msb_first_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            msb_first_q <= msb_first_d;
        end
    end

    assign nibble_o = msb_first_q ? data_q[DATA_WIDTH-1 -: NIBBLE_W] : data_q[NIBBLE_W-1:0];

endmodule

// File: rtl/ram_rdata_nibble_serializer.sv
// Serialises RAM read words into 4-bit beats for the RAM_IO pass BEL, with a one-word
// holding register so consecutive words stream without idle beats.
module ram_rdata_nibble_serializer
    import ram_io_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NoConfigBits = 2
) (
    input  logic                    UserCLK,
    input  logic                    RESET,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdValid,
    output logic                    RdReady,
    input  logic                    Stall,
    input  logic [NoConfigBits-1:0] ConfigBits,
    output logic                    O0,
    output logic                    O1,
    output logic                    O2,
    output logic                    O3,
    output logic                    Strobe,
    output logic                    Busy
);

    localparam int                BEATS     = beats(DATA_WIDTH);
    localparam int                CNT_W     = $clog2(BEATS);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    ser_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  rd_ready_q, rd_ready_d;
    logic [CNT_W-1:0]      beat_q, beat_d;
    logic                  strobe_q, strobe_d;
    logic [NIBBLE_W-1:0]   idle_nib_q, idle_nib_d;

    logic                  last_beat, xfer, load, advance, drain;
    logic [NIBBLE_W-1:0]   shift_nibble;
    logic [NIBBLE_W-1:0]   o_vec;

    assign last_beat = (beat_q == LAST_BEAT);
    assign xfer      = RdValid && rd_ready_q;
    assign load      = hold_full_q && ((state_q == ST_IDLE) || (last_beat && !Stall));
    assign advance   = (state_q == ST_SHIFT) && !Stall && !last_beat;
    assign drain     = (state_q == ST_SHIFT) && !Stall && last_beat && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        beat_d      = beat_q;
        strobe_d    = strobe_q;
        idle_nib_d  = idle_nib_q;

        // load and xfer are mutually exclusive: RdReady is low whenever hold is full.
        if (load) begin
            hold_full_d = 1'b0;
            beat_d      = '0;
            strobe_d    = 1'b1;
            state_d     = ST_SHIFT;
        end else if (xfer) begin
            hold_d      = RdData;
            hold_full_d = 1'b1;
        end

        if (advance) begin
            beat_d   = beat_q + 1'b1;
            strobe_d = 1'b0;
        end

        if (drain) begin
            state_d    = ST_IDLE;
            strobe_d   = 1'b0;
            idle_nib_d = ConfigBits[CFG_IDLE_BIT] ? shift_nibble : '0;
        end

        rd_ready_d = !hold_full_d;
    end

    always_ff @(posedge UserCLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rd_ready_q  <= 1'b1;
            beat_q      <= '0;
            strobe_q    <= 1'b0;
            idle_nib_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rd_ready_q  <= rd_ready_d;
            beat_q      <= beat_d;
            strobe_q    <= strobe_d;
            idle_nib_q  <= idle_nib_d;
        end
    end

    nibble_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift (
        .clk         (UserCLK),
        .srst        (RESET),
        .load_i      (load),
        .shift_i     (advance),
        .msb_first_i (ConfigBits[CFG_ORDER_BIT]),
        .data_i      (hold_q),
        .nibble_o    (shift_nibble)
    );

    assign o_vec   = (state_q == ST_SHIFT) ? shift_nibble : idle_nib_q;
    assign O0      = o_vec[0];
    assign O1      = o_vec[1];
    assign O2      = o_vec[2];
    assign O3      = o_vec[3];
    assign Strobe  = strobe_q;
    assign Busy    = (state_q == ST_SHIFT);
    assign RdReady = rd_ready_q;

endmodule

// File: tb/tb_ram_rdata_nibble_serializer.sv
// Directed bench for the RAM read-data nibble serializer.
module tb_ram_rdata_nibble_serializer;

    logic        UserCLK;
    logic        RESET;
    logic [31:0] RdData;
    logic        RdValid;
    logic        RdReady;
    logic        Stall;
    logic [1:0]  ConfigBits;
    logic        O0, O1, O2, O3;
    logic        Strobe;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    ram_rdata_nibble_serializer #(
        .DATA_WIDTH   (32),
        .NoConfigBits (2)
    ) dut (
        .UserCLK    (UserCLK),
        .RESET      (RESET),
        .RdData     (RdData),
        .RdValid    (RdValid),
        .RdReady    (RdReady),
        .Stall      (Stall),
        .ConfigBits (ConfigBits),
        .O0         (O0),
        .O1         (O1),
        .O2         (O2),
        .O3         (O3),
        .Strobe     (Strobe),
        .Busy       (Busy)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    function automatic logic [31:0] nib();
        return {28'd0, O3, O2, O1, O0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge UserCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  exp_seq [0:10];
        logic [31:0] sb [0:1];
        logic [31:0] w;

        RESET = 1'b1; RdData = '0; RdValid = 1'b0; Stall = 1'b0; ConfigBits = 2'b00;
        step();
        RESET = 1'b0;
        check("reset_O", nib(), 32'h0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_strobe", {31'd0, Strobe}, 32'd0);
        check("reset_rdready", {31'd0, RdReady}, 32'd1);

        // 1: LSB-first, idle drives zero
        RdData = 32'h87654321; RdValid = 1'b1;
        step();
        RdValid = 1'b0;
        check("t1_rdready_full", {31'd0, RdReady}, 32'd0);
        check("t1_busy_pre", {31'd0, Busy}, 32'd0);
        step();
        for (int b = 0; b < 8; b++) begin
            $display("t1 beat %0d O=%0h strobe=%0b busy=%0b", b, nib(), Strobe, Busy);
            check("t1_O", nib(), 32'(b + 1));
            check("t1_strobe", {31'd0, Strobe}, (b == 0) ? 32'd1 : 32'd0);
            check("t1_busy", {31'd0, Busy}, 32'd1);
            step();
        end
        check("t1_busy_end", {31'd0, Busy}, 32'd0);
        check("t1_O_idle", nib(), 32'h0);

        // 2: MSB-first, idle holds last nibble
        ConfigBits = 2'b11;
        RdData = 32'h87654321; RdValid = 1'b1;
        step();
        RdValid = 1'b0;
        step();
        for (int b = 0; b < 8; b++) begin
            $display("t2 beat %0d O=%0h strobe=%0b", b, nib(), Strobe);
            check("t2_O", nib(), 32'(8 - b));
            check("t2_strobe", {31'd0, Strobe}, (b == 0) ? 32'd1 : 32'd0);
            step();
        end
        check("t2_busy_end", {31'd0, Busy}, 32'd0);
        check("t2_O_hold", nib(), 32'h1);
        step();
        check("t2_O_hold2", nib(), 32'h1);

        // 3: back-to-back words with RdValid held high
        ConfigBits = 2'b00;
        RdData = 32'hAAAAAAAA; RdValid = 1'b1;
        step();
        check("t3_rdready_after_a", {31'd0, RdReady}, 32'd0);
        RdData = 32'h55555555;
        step();
        for (int i = 0; i < 16; i++) begin
            $display("t3 beat %0d O=%0h strobe=%0b rdready=%0b", i, nib(), Strobe, RdReady);
            check("t3_O", nib(), (i < 8) ? 32'hA : 32'h5);
            check("t3_strobe", {31'd0, Strobe}, (i == 0 || i == 8) ? 32'd1 : 32'd0);
            check("t3_busy", {31'd0, Busy}, 32'd1);
            if (i == 0) check("t3_rdready_empty", {31'd0, RdReady}, 32'd1);
            if (i == 8) check("t3_rdready_refill", {31'd0, RdReady}, 32'd1);
            step();
            if (i == 0) begin
                RdValid = 1'b0;
                check("t3_rdready_full", {31'd0, RdReady}, 32'd0);
            end
        end
        check("t3_busy_end", {31'd0, Busy}, 32'd0);
        check("t3_O_idle", nib(), 32'h0);

        // 4: three stalled cycles at beat 3
        exp_seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h4, 4'h4, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        RdData = 32'h87654321; RdValid = 1'b1;
        step();
        RdValid = 1'b0;
        step();
        for (int c = 0; c < 11; c++) begin
            $display("t4 cycle %0d O=%0h strobe=%0b stall=%0b", c, nib(), Strobe, Stall);
            check("t4_O", nib(), {28'd0, exp_seq[c]});
            check("t4_strobe", {31'd0, Strobe}, (c == 0) ? 32'd1 : 32'd0);
            check("t4_busy", {31'd0, Busy}, 32'd1);
            Stall = (c >= 3 && c <= 5);
            step();
        end
        Stall = 1'b0;
        check("t4_busy_end", {31'd0, Busy}, 32'd0);
        check("t4_O_idle", nib(), 32'h0);

        // 5: reset mid-word with hold full
        RdData = 32'h87654321; RdValid = 1'b1;
        step();
        RdValid = 1'b0;
        step();
        RdData = 32'hFEDCBA98; RdValid = 1'b1;
        step();
        RdValid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("t5_O_beat5", nib(), 32'h6);
        check("t5_rdready_full", {31'd0, RdReady}, 32'd0);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        $display("t5 after reset O=%0h busy=%0b strobe=%0b rdready=%0b", nib(), Busy, Strobe, RdReady);
        check("t5_O", nib(), 32'h0);
        check("t5_busy", {31'd0, Busy}, 32'd0);
        check("t5_strobe", {31'd0, Strobe}, 32'd0);
        check("t5_rdready", {31'd0, RdReady}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            step();
            check("t5_quiet_O", nib(), 32'h0);
            check("t5_quiet_busy", {31'd0, Busy}, 32'd0);
        end

        // 6: words offered while RdReady is low must be ignored
        sb[0] = 32'h13579BDF;
        sb[1] = 32'h2468ACE0;
        RdData = sb[0]; RdValid = 1'b1;
        step();
        RdData = 32'hDEADBEEF;
        step();
        for (int i = 0; i < 16; i++) begin
            w = sb[i / 8];
            $display("t6 beat %0d O=%0h expected=%0h", i, nib(), (w >> (4 * (i % 8))) & 32'hF);
            check("t6_O", nib(), (w >> (4 * (i % 8))) & 32'hF);
            check("t6_strobe", {31'd0, Strobe}, (i == 0 || i == 8) ? 32'd1 : 32'd0);
            if (i == 0) begin
                RdData = sb[1]; RdValid = 1'b1;
            end else if (i == 1) begin
                RdData = 32'hCAFEF00D; RdValid = 1'b1;
            end else begin
                RdValid = 1'b0;
            end
            step();
        end
        check("t6_busy_end", {31'd0, Busy}, 32'd0);
        check("t6_O_idle", nib(), 32'h0);
        check("t6_rdready_end", {31'd0, RdReady}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
